adder_rr_arbiter: RTL
=====================

// Module: adder_rr_arbiter
// PURPOSE
//  Round-robin arbiter sharing one 25-bit REQ/ACK adder among NUM_REQ clients.
//  Grants one client at a time and latches that client's operands.
//  Runs the 4-phase handshake toward the adder and returns sum/carry with a
//  one-cycle ack to the granted client. Sits between FPU mantissa stages and
//  the single shared adder instance.
// PARAMETERS
//  NUM_REQ      4   number of clients (>=2)
//  WIDTH        25  operand/sum width (must match adder operand width)
//  TIMEOUT_CYC  16  max ISSUE cycles before abort (ADD_ARB_TIMEOUT_EN only)
// PORTS
//  CLK        in   1              clock
//  RSTN       in   1              reset, synchronous, active-low
//  cli_req    in   NUM_REQ        per-client level request (4-phase)
//  cli_a      in   NUM_REQ*WIDTH  client operands A, client i at [i*WIDTH +: WIDTH]
//  cli_b      in   NUM_REQ*WIDTH  client operands B, same packing
//  cli_ack    out  NUM_REQ        one-cycle done pulse, one-hot
//  cli_z      out  WIDTH          result; valid only in the cli_ack cycle
//  cli_cout   out  1              carry-out; valid only in the cli_ack cycle
//  cli_err    out  1              timeout abort flag, with cli_ack (macro only)
//  gnt_id     out  clog2(NUM_REQ) index of the current/last granted client
//  busy       out  1              high in any state other than ARB_IDLE
//  add_req    out  1              request to adder (registered)
//  add_a      out  WIDTH          operand A to adder (registered)
//  add_b      out  WIDTH          operand B to adder (registered)
//  add_ack    in   1              adder ack pulse
//  add_z      in   WIDTH          adder sum; valid when add_ack=1
//  add_cout   in   1              adder carry; valid when add_ack=1
// BEHAVIOUR
//  Reset: all outputs 0, state ARB_IDLE, rr pointer 0, served mask 0.
//  The adder resets on the same RSTN. Reset mid-operation drops all state;
//  no ack is issued for the aborted operation.
//  Eligibility: elig[i] = cli_req[i] & ~served[i].
//  - served[i] is set when cli_ack[i] pulses.
//  - served[i] is cleared when cli_req[i] is sampled 0.
//  - A client must drop its req before it can be granted again.
//  FSM:
//  - ARB_IDLE: if any elig bit is set, grant the first elig index at or after
//    ptr, cyclic. Register gnt_id, add_a and add_b from that client's operands,
//    set add_req=1 and go to ARB_ISSUE. If no bit is set, stay in ARB_IDLE.
//  - ARB_ISSUE: hold add_req and the operands. When add_ack=1:
//    - register cli_z<=add_z and cli_cout<=add_cout;
//    - drive cli_ack[gnt_id]=1 in the next cycle;
//    - set add_req<=0 and ptr<=gnt_id+1 (wraps NUM_REQ-1 -> 0);
//    - go to ARB_RELEASE.
//  - ARB_RELEASE: one cycle, add_req=0, so the adder returns to its compute
//    state. cli_ack and cli_z are valid here; cli_z/cli_cout return to 0 after.
//    Next state is ARB_IDLE.
//  Latency: req sampled in IDLE at cycle 0 -> add_req high cycle 1 -> add_ack
//  cycle 2 -> cli_ack cycle 3. Peak throughput is 1 operation per 4 cycles.
//  Sum is the full WIDTH-bit modular result; overflow appears on cout only.
//  A grant is not revoked if the client drops cli_req during ISSUE; the result
//  is still acked to that client.
//  Simultaneous requests are resolved by the rr pointer only; no client starves.
// CONFIGURATION
//  ADD_ARB_TIMEOUT_EN defined:
//  - Counter runs in ARB_ISSUE. On TIMEOUT_CYC cycles without add_ack, go to
//    ARB_RELEASE with add_req=0, cli_ack[gnt_id]=1, cli_err=1, cli_z=0.
//  - The rr pointer advances as for a normal completion.
//  Macro undefined: no counter and no cli_err port; ARB_ISSUE waits indefinitely.
// STRUCTURE
//  Package adder_pkg: typedef enum ArbState {ARB_IDLE, ARB_ISSUE, ARB_RELEASE},
//  localparam ADD_WIDTH=25.
//  Sub-module rr_pick: combinational; inputs elig and ptr, outputs index and any.
//  Top level holds the FSM, operand/result registers, served mask and optional
//  timeout counter. The bench instantiates the real adder on the add_* side.
// TESTING
//  1. Single client 0: A=25'h0FFFFFF, B=1 -> cli_ack[0] at cycle 3,
//     cli_z=25'h1000000, cli_cout=0.
//  2. Overflow: A=B=25'h1FFFFFF -> cli_z=25'h1FFFFFE, cli_cout=1.
//  3. All 4 clients request at once with ptr=0 -> acks in order 0,1,2,3,
//     spaced 4 cycles apart, each with its own correct sum.
//  4. Client 2 holds req high after its ack -> not re-granted until req is low
//     for 1 cycle; client 3 is granted in the meantime.
//  5. RSTN low during ARB_ISSUE -> next cycle all outputs 0, no cli_ack;
//     a fresh request completes normally after reset.
//  6. ADD_ARB_TIMEOUT_EN with the adder model suppressing ack -> after 16 ISSUE
//     cycles, cli_ack=1 and cli_err=1 for the granted client, then ARB_IDLE.

Source files
------------

// File: rtl/adder_pkg.sv
// ----------------------------------------------------------------------------
// adder_pkg
//   Shared types and helpers for the round-robin adder arbiter.
//   - ADD_WIDTH : operand/sum width of the shared adder
//   - ArbState  : arbiter FSM state encoding
//   - wrap_add  : cyclic index addition used by the rr pointer and picker
// ----------------------------------------------------------------------------
package adder_pkg;

  localparam int ADD_WIDTH = 25;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_ISSUE   = 2'd1,
    ARB_RELEASE = 2'd2
  } ArbState;

  // (v + k) mod n, assuming v < n and k < n so one subtraction suffices.
  function automatic int wrap_add(input int v, input int k, input int n);
    int s;
    s = v + k;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/adder_rr_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker: finds the first set bit of elig at or
//   after index ptr, wrapping cyclically.
// Ports:
//   elig  in   NUM_REQ          eligible clients
//   ptr   in   clog2(NUM_REQ)   search start index
//   index out  clog2(NUM_REQ)   selected client (0 when none)
//   any   out  1                at least one client eligible
// ----------------------------------------------------------------------------
module rr_pick
  import adder_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         elig,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [$clog2(NUM_REQ)-1:0] index,
  output logic                       any
);

  localparam int IDW = $clog2(NUM_REQ);

  logic [IDW-1:0] cand;

  // Scan from the farthest offset down to offset 0 so the candidate closest
  // to ptr is the last one written and therefore wins.
  always_comb begin
    index = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IDW'(wrap_add(int'(ptr), k, NUM_REQ));
      if (elig[cand]) begin
        index = cand;
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_rr_arbiter.sv
// ----------------------------------------------------------------------------
// adder_rr_arbiter
//   Round-robin arbiter sharing one REQ/ACK adder among NUM_REQ clients.
//   Grants one client, latches its operands, runs the 4-phase handshake to the
//   adder and returns sum/carry with a one-cycle ack to the granted client.
//
// Optional feature: define ADD_ARB_TIMEOUT_EN to abort an ISSUE phase that
//   sees no add_ack within TIMEOUT_CYC cycles (adds port cli_err).
//
// Ports:
//   CLK, RSTN          clock; synchronous active-low reset
//   cli_req            per-client level request
//   cli_a, cli_b       packed client operands, client i at [i*WIDTH +: WIDTH]
//   cli_ack            one-hot done pulse
//   cli_z, cli_cout    result, valid only with cli_ack
//   cli_err            timeout abort flag with cli_ack (ADD_ARB_TIMEOUT_EN)
//   gnt_id             current/last granted client
//   busy               FSM not in ARB_IDLE
//   add_req/a/b        registered request and operands to the adder
//   add_ack/z/cout     adder ack pulse and result
//
// FSM states:
//   state       | meaning
//   ARB_IDLE    | waiting for an eligible client
//   ARB_ISSUE   | add_req held high, waiting for add_ack (or timeout)
//   ARB_RELEASE | add_req low, cli_ack/cli_z valid for one cycle
// ----------------------------------------------------------------------------
module adder_rr_arbiter
  import adder_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = ADD_WIDTH
`ifdef ADD_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 16
`endif
) (
  input  logic                       CLK,
  input  logic                       RSTN,
  input  logic [NUM_REQ-1:0]         cli_req,
  input  logic [NUM_REQ*WIDTH-1:0]   cli_a,
  input  logic [NUM_REQ*WIDTH-1:0]   cli_b,
  output logic [NUM_REQ-1:0]         cli_ack,
  output logic [WIDTH-1:0]           cli_z,
  output logic                       cli_cout,
`ifdef ADD_ARB_TIMEOUT_EN
  output logic                       cli_err,
`endif
  output logic [$clog2(NUM_REQ)-1:0] gnt_id,
  output logic                       busy,
  output logic                       add_req,
  output logic [WIDTH-1:0]           add_a,
  output logic [WIDTH-1:0]           add_b,
  input  logic                       add_ack,
  input  logic [WIDTH-1:0]           add_z,
  input  logic                       add_cout
);

  localparam int IDW = $clog2(NUM_REQ);

  ArbState              state_q, state_d;
  logic [NUM_REQ-1:0]   served_q, served_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [IDW-1:0]       gnt_id_q, gnt_id_d;
  logic [NUM_REQ-1:0]   cli_ack_q, cli_ack_d;
  logic [WIDTH-1:0]     cli_z_q, cli_z_d;
  logic                 cli_cout_q, cli_cout_d;
  logic                 add_req_q, add_req_d;
  logic [WIDTH-1:0]     add_a_q, add_a_d;
  logic [WIDTH-1:0]     add_b_q, add_b_d;

  logic [NUM_REQ-1:0]   elig;
  logic [IDW-1:0]       pick_idx;
  logic                 pick_any;
  logic [NUM_REQ-1:0]   gnt_onehot;
  logic [IDW-1:0]       ptr_next;

`ifdef ADD_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic                 cli_err_q, cli_err_d;
  logic [TW-1:0]        tmo_q, tmo_d;
`endif

  assign elig       = cli_req & ~served_q;
  assign gnt_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_id_q;
  assign ptr_next   = IDW'(wrap_add(int'(gnt_id_q), 1, NUM_REQ));

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .elig  (elig),
    .ptr   (ptr_q),
    .index (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_id_d   = gnt_id_q;
    add_req_d  = add_req_q;
    add_a_d    = add_a_q;
    add_b_d    = add_b_q;
    // Result outputs are pulses: they default to zero every cycle.
    cli_ack_d  = '0;
    cli_z_d    = '0;
    cli_cout_d = 1'b0;
`ifdef ADD_ARB_TIMEOUT_EN
    cli_err_d  = 1'b0;
    tmo_d      = tmo_q;
`endif
    // A served bit survives only while its client keeps requesting, so a
    // client has to drop req for at least one cycle to become eligible again.
    served_d   = (served_q | cli_ack_q) & cli_req;

    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          gnt_id_d  = pick_idx;
          add_a_d   = cli_a[pick_idx*WIDTH +: WIDTH];
          add_b_d   = cli_b[pick_idx*WIDTH +: WIDTH];
          add_req_d = 1'b1;
`ifdef ADD_ARB_TIMEOUT_EN
          tmo_d     = TW'(TIMEOUT_CYC - 1);
`endif
          state_d   = ARB_ISSUE;
        end
      end

      ARB_ISSUE: begin
        if (add_ack) begin
          cli_z_d    = add_z;
          cli_cout_d = add_cout;
          cli_ack_d  = gnt_onehot;
          add_req_d  = 1'b0;
          ptr_d      = ptr_next;
          state_d    = ARB_RELEASE;
        end
`ifdef ADD_ARB_TIMEOUT_EN
        else if (tmo_q == '0) begin
          cli_ack_d  = gnt_onehot;
          cli_err_d  = 1'b1;
          add_req_d  = 1'b0;
          ptr_d      = ptr_next;
          state_d    = ARB_RELEASE;
        end else begin
          tmo_d      = tmo_q - TW'(1);
        end
`endif
      end

      ARB_RELEASE: begin
        add_req_d = 1'b0;
        state_d   = ARB_IDLE;
      end

      default: begin
        add_req_d = 1'b0;
        state_d   = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q    <= ARB_IDLE;
      served_q   <= '0;
      ptr_q      <= '0;
      gnt_id_q   <= '0;
      cli_ack_q  <= '0;
      cli_z_q    <= '0;
      cli_cout_q <= 1'b0;
      add_req_q  <= 1'b0;
      add_a_q    <= '0;
      add_b_q    <= '0;
`ifdef ADD_ARB_TIMEOUT_EN
      cli_err_q  <= 1'b0;
      tmo_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      served_q   <= served_d;
      ptr_q      <= ptr_d;
      gnt_id_q   <= gnt_id_d;
      cli_ack_q  <= cli_ack_d;
      cli_z_q    <= cli_z_d;
      cli_cout_q <= cli_cout_d;
      add_req_q  <= add_req_d;
      add_a_q    <= add_a_d;
      add_b_q    <= add_b_d;
`ifdef ADD_ARB_TIMEOUT_EN
      cli_err_q  <= cli_err_d;
      tmo_q      <= tmo_d;
`endif
    end
  end

  assign cli_ack  = cli_ack_q;
  assign cli_z    = cli_z_q;
  assign cli_cout = cli_cout_q;
  assign gnt_id   = gnt_id_q;
  assign busy     = (state_q != ARB_IDLE);
  assign add_req  = add_req_q;
  assign add_a    = add_a_q;
  assign add_b    = add_b_q;
`ifdef ADD_ARB_TIMEOUT_EN
  assign cli_err  = cli_err_q;
`endif

endmodule
